if_stage: RTL

Instruction-fetch stage of the five-stage pipelined MIPS datapath: holds the PC, reads word-addressed instruction memory, and drives the IF/ID pipeline register consumed by the decode stage. It obeys the hazard detection unit's stall request (load-use) and the decode stage's branch flush. It also carries a program-load port so benches can preload code before releasing reset.

---
 rtl/mips_pkg.sv | 8 +
 rtl/instr_mem.sv | 27 ++
 rtl/if_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the pipelined MIPS datapath.
package mips_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction memory: one synchronous write port, one asynchronous read port.
module instr_mem
    import mips_pkg::*;
#(
    parameter int IMEM_WORDS = 32
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(IMEM_WORDS)-1:0] waddr,
    input  logic [INSTR_WIDTH-1:0]        wdata,
    input  logic [$clog2(IMEM_WORDS)-1:0] raddr,
    output logic [INSTR_WIDTH-1:0]        rdata
);

    logic [INSTR_WIDTH-1:0] mem [IMEM_WORDS];

    // No reset on the array: code loaded while the pipeline is held in reset must survive it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write to raddr is not visible until after the edge, so reads see the old word.
    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect/stall priority, IF/ID register and stall counter.
module if_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_WORDS = 32,
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          flush,
    input  logic [31:0]                   branch_target,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_WORDS)-1:0] imem_waddr,
    input  logic [INSTR_WIDTH-1:0]        imem_wdata,
    output logic [INSTR_WIDTH-1:0]        ifid_instr,
    output logic [31:0]                   ifid_pc_plus4,
    output logic                          ifid_valid,
    output logic [31:0]                   pc,
    output logic [15:0]                   stall_count
);

    localparam int IDX = $clog2(IMEM_WORDS);

    logic [31:0]             pc_q, pc_d;
    logic [INSTR_WIDTH-1:0]  instr_q, instr_d;
    logic [31:0]             pcPlus4_q, pcPlus4_d;
    logic                    valid_q, valid_d;
    logic [15:0]             stallCnt_q, stallCnt_d;
    logic [INSTR_WIDTH-1:0]  fetchWord;
    logic [31:0]             pcPlus4;

    instr_mem #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q[IDX+1:2]),
        .rdata (fetchWord)
    );

    assign pcPlus4 = pc_q + 32'd4;

    // Flush beats stall: a redirected PC makes the stalled IF/ID contents stale anyway.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pcPlus4_d  = pcPlus4_q;
        valid_d    = valid_q;
        stallCnt_d = stallCnt_q;
        if (flush) begin
            pc_d      = branch_target & ~32'h3;
            instr_d   = NOP_INSTR;
            pcPlus4_d = 32'h0;
            valid_d   = 1'b0;
        end else if (stall) begin
            if (stallCnt_q != 16'hFFFF) begin
                stallCnt_d = stallCnt_q + 16'd1;
            end
        end else begin
            pc_d      = pcPlus4;
            instr_d   = fetchWord;
            pcPlus4_d = pcPlus4;
            valid_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            pcPlus4_q  <= 32'h0;
            valid_q    <= 1'b0;
            stallCnt_q <= 16'h0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pcPlus4_q  <= pcPlus4_d;
            valid_q    <= valid_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    assign pc            = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus4 = pcPlus4_q;
    assign ifid_valid    = valid_q;
    assign stall_count   = stallCnt_q;

endmodule
